// File: rtl/rtc_clock_core.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_clock_core
//  Purpose  : Time-of-day counter (hh:mm:ss) driven by a divided system clock.
//             Plus/minus field setting with hold-to-repeat, 12/24-hour display
//             conversion, a daily alarm comparator and one-cycle strobes for
//             seconds, day wrap and alarm hits.
//  Revision : 1.0  initial release
// ============================================================================
module rtc_clock_core #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int REPEAT_DLY  = 25_000_000,
  parameter int REPEAT_RATE = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       plus,
  input  logic       minus,
  input  logic [1:0] mode,
  input  logic       fmt12,
  input  logic       alarm_en,
  input  logic [4:0] alarm_h,
  input  logic [5:0] alarm_m,
  output logic [4:0] hours,
  output logic [4:0] disp_hours,
  output logic       pm,
  output logic [5:0] mins,
  output logic [5:0] secs,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       alarm_match
);

  // --------------------------------------------------------------------------
  // Derived sizes and constants
  // --------------------------------------------------------------------------
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [RPT_W-1:0] RPT_DLY_C = RPT_W'(REPEAT_DLY);
  localparam logic [RPT_W-1:0] RPT_RATE_C = RPT_W'(REPEAT_RATE);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_SEC  = 2'b01;
  localparam logic [1:0] MODE_MIN  = 2'b10;
  localparam logic [1:0] MODE_HOUR = 2'b11;

  // Button auto-repeat sequencer: waiting for a press, counting the initial
  // hold delay, then stepping at the repeat rate.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q,   div_d;
  logic [5:0]       secs_q,  secs_d;
  logic [5:0]       mins_q,  mins_d;
  logic [4:0]       hours_q, hours_d;

  logic             plus_q;
  logic             minus_q;
  logic [1:0]       mode_q;

  rpt_state_t       rpt_state_q, rpt_state_d;
  logic             rpt_up_q,    rpt_up_d;
  logic [RPT_W-1:0] rpt_cnt_q,   rpt_cnt_d;

  logic             sec_pulse_q,  sec_pulse_d;
  logic             day_pulse_q,  day_pulse_d;
  logic             alarm_q,      alarm_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic run_mode;
  logic mode_chg;
  logic tick;
  logic press_up;
  logic press_dn;
  logic hold_up;
  logic hold_dn;
  logic held_same;
  logic step_up;
  logic step_dn;

  // Wrap a 0..59 field by one step in either direction, no carry out.
  function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
    if (up) begin
      return (v == 6'd59) ? 6'd0 : v + 6'd1;
    end
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  // Wrap a 0..23 field by one step in either direction, no carry out.
  function automatic logic [4:0] step24(input logic [4:0] v, input logic up);
    if (up) begin
      return (v == 5'd23) ? 5'd0 : v + 5'd1;
    end
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  // Decode run/set context and classify the button inputs against last cycle.
  always_comb begin
    run_mode  = (mode == MODE_RUN);
    mode_chg  = (mode != mode_q);
    tick      = run_mode && enable && (div_q == DIV_LAST);
    press_up  = plus  && !minus && !plus_q;
    press_dn  = minus && !plus  && !minus_q;
    hold_up   = plus  && !minus && plus_q;
    hold_dn   = minus && !plus  && minus_q;
    held_same = rpt_up_q ? hold_up : hold_dn;
  end

  // Auto-repeat next state: a fresh press steps at once; a continued hold of
  // the same single button steps after REPEAT_DLY and then every REPEAT_RATE.
  // Run mode, a mode change, release, or both buttons abandon the sequence.
  always_comb begin
    rpt_state_d = rpt_state_q;
    rpt_up_d    = rpt_up_q;
    rpt_cnt_d   = rpt_cnt_q;
    step_up     = 1'b0;
    step_dn     = 1'b0;

    if (run_mode || mode_chg) begin
      rpt_state_d = RPT_IDLE;
      rpt_cnt_d   = '0;
    end else if (press_up || press_dn) begin
      step_up     = press_up;
      step_dn     = press_dn;
      rpt_up_d    = press_up;
      rpt_state_d = RPT_DELAY;
      rpt_cnt_d   = RPT_ONE;
    end else begin
      case (rpt_state_q)
        RPT_DELAY: begin
          if (!held_same) begin
            rpt_state_d = RPT_IDLE;
            rpt_cnt_d   = '0;
          end else if (rpt_cnt_q == RPT_DLY_C) begin
            step_up     = rpt_up_q;
            step_dn     = !rpt_up_q;
            rpt_state_d = RPT_REPEAT;
            rpt_cnt_d   = RPT_ONE;
          end else begin
            rpt_cnt_d   = rpt_cnt_q + RPT_ONE;
          end
        end
        RPT_REPEAT: begin
          if (!held_same) begin
            rpt_state_d = RPT_IDLE;
            rpt_cnt_d   = '0;
          end else if (rpt_cnt_q == RPT_RATE_C) begin
            step_up     = rpt_up_q;
            step_dn     = !rpt_up_q;
            rpt_cnt_d   = RPT_ONE;
          end else begin
            rpt_cnt_d   = rpt_cnt_q + RPT_ONE;
          end
        end
        default: begin
          rpt_state_d = RPT_IDLE;
          rpt_cnt_d   = '0;
        end
      endcase
    end
  end

  // Auto-repeat state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_state_q <= RPT_IDLE;
      rpt_up_q    <= 1'b0;
      rpt_cnt_q   <= '0;
    end else begin
      rpt_state_q <= rpt_state_d;
      rpt_up_q    <= rpt_up_d;
      rpt_cnt_q   <= rpt_cnt_d;
    end
  end

  // Previous-cycle copies of the buttons and mode for edge/change detection.
  // Reset loads the live mode so coming out of reset is not seen as a change.
  always_ff @(posedge clk) begin
    if (reset) begin
      plus_q  <= 1'b0;
      minus_q <= 1'b0;
      mode_q  <= mode;
    end else begin
      plus_q  <= plus;
      minus_q <= minus;
      mode_q  <= mode;
    end
  end

  // Next time value: prescaler, seconds tick with carry chain in run mode,
  // single-field wrap edits in set modes; strobes only on a run-mode tick.
  always_comb begin
    div_d       = div_q;
    secs_d      = secs_q;
    mins_d      = mins_q;
    hours_d     = hours_q;
    sec_pulse_d = 1'b0;
    day_pulse_d = 1'b0;
    alarm_d     = 1'b0;

    if (!run_mode) begin
      // Parked at zero so returning to run starts a full second.
      div_d = '0;
      case (mode)
        MODE_SEC:  if (step_up || step_dn) secs_d  = step60(secs_q,  step_up);
        MODE_MIN:  if (step_up || step_dn) mins_d  = step60(mins_q,  step_up);
        MODE_HOUR: if (step_up || step_dn) hours_d = step24(hours_q, step_up);
        default: ;
      endcase
    end else if (enable) begin
      if (tick) begin
        div_d  = '0;
        secs_d = step60(secs_q, 1'b1);
        if (secs_q == 6'd59) begin
          mins_d = step60(mins_q, 1'b1);
          if (mins_q == 6'd59) begin
            hours_d = step24(hours_q, 1'b1);
          end
        end
        sec_pulse_d = 1'b1;
        day_pulse_d = (secs_q == 6'd59) && (mins_q == 6'd59) && (hours_q == 5'd23);
        alarm_d     = alarm_en && (secs_d == 6'd0) &&
                      (mins_d == alarm_m) && (hours_d == alarm_h);
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end
  end

  // Time, prescaler and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      secs_q      <= '0;
      mins_q      <= '0;
      hours_q     <= '0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      div_q       <= div_d;
      secs_q      <= secs_d;
      mins_q      <= mins_d;
      hours_q     <= hours_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
      alarm_q     <= alarm_d;
    end
  end

  // 12/24-hour display conversion; midnight and noon both show 12.
  always_comb begin
    disp_hours = hours_q;
    pm         = 1'b0;
    if (fmt12) begin
      if (hours_q == 5'd0) begin
        disp_hours = 5'd12;
      end else if (hours_q < 5'd12) begin
        disp_hours = hours_q;
      end else if (hours_q == 5'd12) begin
        disp_hours = 5'd12;
        pm         = 1'b1;
      end else begin
        disp_hours = hours_q - 5'd12;
        pm         = 1'b1;
      end
    end
  end

  assign hours       = hours_q;
  assign mins        = mins_q;
  assign secs        = secs_q;
  assign sec_pulse   = sec_pulse_q;
  assign day_pulse   = day_pulse_q;
  assign alarm_match = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_clock_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_clock_core
//  Purpose  : Self-checking bench for rtc_clock_core: directed scenarios then
//             random button/mode traffic against a seconds-of-day model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rtc_clock_core;

  localparam int TDIV = 4;
  localparam int RDLY = 6;
  localparam int RRAT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       plus = 1'b0;
  logic       minus = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       fmt12 = 1'b0;
  logic       alarm_en = 1'b0;
  logic [4:0] alarm_h = 5'd0;
  logic [5:0] alarm_m = 6'd0;
  logic [4:0] hours;
  logic [4:0] disp_hours;
  logic       pm;
  logic [5:0] mins;
  logic [5:0] secs;
  logic       sec_pulse;
  logic       day_pulse;
  logic       alarm_match;

  int errors = 0;
  int checks = 0;

  rtc_clock_core #(
    .TICK_DIV   (TDIV),
    .REPEAT_DLY (RDLY),
    .REPEAT_RATE(RRAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .plus       (plus),
    .minus      (minus),
    .mode       (mode),
    .fmt12      (fmt12),
    .alarm_en   (alarm_en),
    .alarm_h    (alarm_h),
    .alarm_m    (alarm_m),
    .hours      (hours),
    .disp_hours (disp_hours),
    .pm         (pm),
    .mins       (mins),
    .secs       (secs),
    .sec_pulse  (sec_pulse),
    .day_pulse  (day_pulse),
    .alarm_match(alarm_match)
  );

  always #5 clk = ~clk;

  // Reference model state: time as h/m/s, prescaler position, and the number
  // of cycles the current single button has been held since its press (-1 none).
  int   mh = 0, mm = 0, ms = 0, presc = 0, held = -1;
  bit   hdir = 1'b0;
  bit   prev_plus = 1'b0, prev_minus = 1'b0;
  logic [1:0] prev_mode = 2'b00;
  bit   e_sp = 1'b0, e_dp = 1'b0, e_am = 1'b0;

  task automatic model_edge();
    int tod;
    int stp;
    bit up;
    e_sp = 1'b0; e_dp = 1'b0; e_am = 1'b0;
    if (reset) begin
      mh = 0; mm = 0; ms = 0; presc = 0; held = -1;
      prev_plus = 1'b0; prev_minus = 1'b0; prev_mode = mode;
    end else begin
      if (mode == 2'b00) begin
        held = -1;
        if (enable) begin
          if (presc == TDIV - 1) begin
            presc = 0;
            tod = (mh * 3600 + mm * 60 + ms + 1) % 86400;
            mh = tod / 3600; mm = (tod / 60) % 60; ms = tod % 60;
            e_sp = 1'b1;
            e_dp = (tod == 0);
            e_am = alarm_en && (ms == 0) && (mh == int'(alarm_h)) && (mm == int'(alarm_m));
          end else begin
            presc++;
          end
        end
      end else begin
        presc = 0;
        stp = 0;
        if (mode != prev_mode) begin
          held = -1;
        end else if (plus ^ minus) begin
          up = plus;
          if (!(up ? prev_plus : prev_minus)) begin
            held = 0; hdir = up; stp = up ? 1 : -1;
          end else if (held >= 0 && up == hdir) begin
            held++;
            if (held >= RDLY && ((held - RDLY) % RRAT) == 0) stp = hdir ? 1 : -1;
          end else begin
            held = -1;
          end
        end else begin
          held = -1;
        end
        if (stp != 0) begin
          case (mode)
            2'b01:   ms = (ms + stp + 60) % 60;
            2'b10:   mm = (mm + stp + 60) % 60;
            default: mh = (mh + stp + 24) % 24;
          endcase
        end
      end
      prev_plus = plus; prev_minus = minus; prev_mode = mode;
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag);
    int dh;
    dh = fmt12 ? (((mh % 12) == 0) ? 12 : (mh % 12)) : mh;
    cmp({tag, ".hours"},  hours,       mh);
    cmp({tag, ".mins"},   mins,        mm);
    cmp({tag, ".secs"},   secs,        ms);
    cmp({tag, ".disp"},   disp_hours,  dh);
    cmp({tag, ".pm"},     pm,          (fmt12 && mh >= 12) ? 1 : 0);
    cmp({tag, ".sec_p"},  sec_pulse,   e_sp);
    cmp({tag, ".day_p"},  day_pulse,   e_dp);
    cmp({tag, ".alarm"},  alarm_match, e_am);
  endtask

  // One clock: update the model with the inputs about to be sampled, then
  // check the DUT shortly after the edge.
  task automatic cyc(input string tag = "cyc");
    model_edge();
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  task automatic tap(input logic [1:0] md, input bit up);
    mode = md; plus = 1'b0; minus = 1'b0; cyc("tap_mode");
    if (up) plus = 1'b1; else minus = 1'b1;
    cyc("tap_press");
    plus = 1'b0; minus = 1'b0; cyc("tap_rel");
  endtask

  function automatic int mfield(input logic [1:0] md);
    return (md == 2'b01) ? ms : (md == 2'b10) ? mm : mh;
  endfunction

  task automatic set_field(input logic [1:0] md, input int target);
    mode = md; plus = 1'b0; minus = 1'b0; cyc("set_mode");
    for (int n = 0; n < 64 && mfield(md) != target; n++) begin
      plus = 1'b1; cyc("set_press");
      plus = 1'b0; cyc("set_rel");
    end
  endtask

  int hv[5] = '{0, 11, 12, 13, 23};
  int dv[5] = '{12, 11, 12, 1, 11};
  int pv[5] = '{0, 0, 1, 1, 1};

  initial begin
    // ---------------- reset state
    reset = 1'b1; cyc("reset");
    reset = 1'b0;
    cmp("rst_hours", hours, 0);
    cmp("rst_secs", secs, 0);
    cmp("rst_disp24", disp_hours, 0);
    fmt12 = 1'b1; #1;
    cmp("rst_disp12", disp_hours, 12);
    cmp("rst_pm12", pm, 0);
    fmt12 = 1'b0;

    // ---------------- 1: day wrap from 23:59:59
    tap(2'b11, 1'b0);
    tap(2'b10, 1'b0);
    tap(2'b01, 1'b0);
    cmp("t1_set_h", hours, 23);
    cmp("t1_set_m", mins, 59);
    cmp("t1_set_s", secs, 59);
    mode = 2'b00; enable = 1'b1;
    for (int i = 0; i < 3; i++) cyc("t1_wait");
    cmp("t1_pre_s", secs, 59);
    cmp("t1_pre_sp", sec_pulse, 0);
    cyc("t1_tick");
    cmp("t1_wrap_h", hours, 0);
    cmp("t1_wrap_m", mins, 0);
    cmp("t1_wrap_s", secs, 0);
    cmp("t1_sp", sec_pulse, 1);
    cmp("t1_dp", day_pulse, 1);
    cyc("t1_after");
    cmp("t1_sp_off", sec_pulse, 0);
    cmp("t1_dp_off", day_pulse, 0);
    enable = 1'b0;
    for (int i = 0; i < 8; i++) cyc("t1_hold");
    cmp("t1_hold_s", secs, 0);
    enable = 1'b1;
    cyc("t1_resume"); cyc("t1_resume");
    cmp("t1_resume_s0", secs, 0);
    cyc("t1_resume");
    cmp("t1_resume_s1", secs, 1);
    enable = 1'b0;
    tap(2'b01, 1'b0);   // secs back to 0

    // ---------------- 2: field wrap without carry/borrow
    tap(2'b10, 1'b0);
    cmp("t2_min_wrap", mins, 59);
    cmp("t2_min_h", hours, 0);
    tap(2'b01, 1'b0);
    cmp("t2_sec59", secs, 59);
    tap(2'b01, 1'b1);
    cmp("t2_sec_wrap", secs, 0);
    cmp("t2_sec_nocarry", mins, 59);

    // ---------------- 3: auto-repeat
    mode = 2'b11; cyc("t3_mode");
    plus = 1'b1;
    for (int i = 0; i < 13; i++) cyc("t3_hold");
    cmp("t3_repeat", hours, 4);
    plus = 1'b0; cyc("t3_rel");
    plus = 1'b1; cyc("t3_repress");
    cmp("t3_repress_h", hours, 5);
    plus = 1'b0; cyc("t3_rel2");

    // ---------------- 4: both buttons, reset mid-hold
    mode = 2'b10; cyc("t4_mode");
    plus = 1'b1; minus = 1'b1;
    for (int i = 0; i < 10; i++) cyc("t4_both");
    cmp("t4_both_m", mins, 59);
    plus = 1'b0; minus = 1'b0; cyc("t4_rel");
    mode = 2'b11; cyc("t4_mode2");
    plus = 1'b1;
    for (int i = 0; i < 3; i++) cyc("t4_hold");
    reset = 1'b1; cyc("t4_reset");
    cmp("t4_rst_h", hours, 0);
    cmp("t4_rst_m", mins, 0);
    reset = 1'b0; plus = 1'b0;
    for (int i = 0; i < 8; i++) cyc("t4_idle");
    cmp("t4_nostep", hours, 0);
    plus = 1'b1; cyc("t4_fresh");
    cmp("t4_fresh_h", hours, 1);
    plus = 1'b0; cyc("t4_rel2");

    // ---------------- 5: 12-hour conversion
    reset = 1'b1; cyc("t5_reset");
    reset = 1'b0;
    fmt12 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_field(2'b11, hv[i]);
      cmp("t5_disp", disp_hours, dv[i]);
      cmp("t5_pm", pm, pv[i]);
      if (hv[i] == 13) begin
        fmt12 = 1'b0; #1;
        cmp("t5_disp24", disp_hours, 13);
        cmp("t5_pm24", pm, 0);
        fmt12 = 1'b1; #1;
      end
    end
    fmt12 = 1'b0;

    // ---------------- 6: alarm
    alarm_en = 1'b1; alarm_h = 5'd7; alarm_m = 6'd30;
    set_field(2'b11, 7);
    set_field(2'b10, 29);
    tap(2'b01, 1'b0);
    mode = 2'b00; enable = 1'b1;
    for (int i = 0; i < 3; i++) cyc("t6_wait");
    cmp("t6_pre_alarm", alarm_match, 0);
    cyc("t6_tick");
    cmp("t6_alarm", alarm_match, 1);
    cmp("t6_alarm_sp", sec_pulse, 1);
    cmp("t6_alarm_m", mins, 30);
    cyc("t6_after");
    cmp("t6_alarm_off", alarm_match, 0);
    enable = 1'b0;
    tap(2'b01, 1'b0); tap(2'b01, 1'b1);   // secs back to 0
    tap(2'b10, 1'b0);
    tap(2'b10, 1'b1);
    cmp("t6_set_m", mins, 30);
    cmp("t6_set_noalarm", alarm_match, 0);
    alarm_en = 1'b0;
    tap(2'b10, 1'b0);
    tap(2'b01, 1'b0);
    mode = 2'b00; enable = 1'b1;
    for (int i = 0; i < 4; i++) cyc("t6_dis");
    cmp("t6_dis_m", mins, 30);
    cmp("t6_dis_sp", sec_pulse, 1);
    cmp("t6_dis_alarm", alarm_match, 0);

    // ---------------- random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0)
        mode = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) plus = ~plus;
      if ($urandom_range(0, 9) == 0) minus = ~minus;
      enable   = ($urandom_range(0, 7) != 0);
      fmt12    = 1'($urandom_range(0, 1));
      alarm_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) begin
        alarm_h = 5'(mh);
        alarm_m = 6'((mm + 1) % 60);
      end
      if ($urandom_range(0, 299) == 0) alarm_h = 5'($urandom_range(24, 31));
      reset = ($urandom_range(0, 599) == 0);
      cyc("rand");
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rtc_clock_core.md
Name: rtc_clock_core

Overview:
Parametrised successor to the board time-of-day counter. It keeps hours, minutes and seconds from a divided system clock and lets the user set each field with plus/minus buttons, including auto-repeat while a button is held. It also provides 12/24-hour display conversion, a daily alarm comparator, and one-cycle second and day strobes. It sits between the debounced button logic and the seven-segment display driver.

Parameters:
TICK_DIV, 50_000_000, clk cycles per second; prescaler counts 0..TICK_DIV-1.
REPEAT_DLY, 25_000_000, clk cycles a button must be held before auto-repeat starts.
REPEAT_RATE, 5_000_000, clk cycles between auto-repeat steps after REPEAT_DLY.
(Derived localparams: DIV_W = $clog2(TICK_DIV); RPT_W = $clog2(max(REPEAT_DLY, REPEAT_RATE)+1).)

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
enable  in  1  run; time advances only when enable=1 and mode=00.
plus  in  1  level, debounced; increment the selected field.
minus  in  1  level, debounced; decrement the selected field.
mode  in  2  00 run, 01 set secs, 10 set mins, 11 set hours.
fmt12  in  1  1 = 12-hour display format.
alarm_en  in  1  alarm compare enable.
alarm_h  in  5  alarm hour, 0-23.
alarm_m  in  6  alarm minute, 0-59.
hours  out  5  internal hour, 0-23.
disp_hours  out  5  display hour (1-12 if fmt12, else equal to hours).
pm  out  1  hours>=12 when fmt12; 0 otherwise.
mins  out  6  0-59.
secs  out  6  0-59.
sec_pulse  out  1  one-cycle strobe on each run-mode seconds tick.
day_pulse  out  1  one-cycle strobe on the 23:59:59 -> 00:00:00 wrap.
alarm_match  out  1  one-cycle strobe when a tick lands on alarm_h:alarm_m:00.

Behaviour:
- Reset (synchronous, highest priority):
  - hours, mins, secs, prescaler, repeat counter, plus_q/minus_q and all strobes go to 0.
  - disp_hours reads 12 if fmt12=1, else 0.
  - Reset mid-hold or mid-tick discards all pending state.
- Prescaler:
  - Counts only while enable=1 and mode=00; wraps TICK_DIV-1 -> 0.
  - Held at 0 whenever mode!=00, so leaving a set mode starts a full second.
  - Holds its value when enable=0 and mode=00.
- Tick: at the edge where the prescaler equals TICK_DIV-1:
  - secs increments; 59 wraps to 0 and carries into mins.
  - mins 59 wraps to 0 and carries into hours.
  - hours 23 wraps to 0.
  - sec_pulse is asserted the cycle the new value is visible. day_pulse is asserted the same cycle when the result is 00:00:00.
- Set modes (01/10/11):
  - Time is frozen and only the selected field changes.
  - Steps wrap within the field with no carry or borrow: secs/mins 0<->59, hours 0<->23.
- Step generation (set modes only):
  - plus_q/minus_q register the previous inputs.
  - A step occurs at the first edge where exactly one of plus/minus is sampled 1 and its _q is 0; the field shows the new value after that edge.
  - While the same single button stays held, the repeat counter runs. Further steps occur at held-cycles REPEAT_DLY, REPEAT_DLY+REPEAT_RATE, +2*REPEAT_RATE, ... counting the initial step as cycle 0.
  - The repeat counter clears on release, when both buttons are 1, on a mode change, or on reset.
  - plus and minus both 1: no step.
  - plus/minus in mode 00: ignored.
- 12-hour conversion (combinational from hours):
  - hours 0 -> 12, pm=0.
  - 1-11 -> same value, pm=0.
  - 12 -> 12, pm=1.
  - 13-23 -> hours-12, pm=1.
  - fmt12=0: disp_hours=hours, pm=0.
- Alarm:
  - alarm_match pulses for one cycle, aligned with sec_pulse, when a run-mode tick produces hours=alarm_h, mins=alarm_m, secs=0 and alarm_en=1.
  - Set-mode edits never trigger it.
  - Out-of-range alarm values never match.
- All strobes are registered, one cycle wide, and 0 in set modes.

Test Plan:
(Benches use TICK_DIV=4, REPEAT_DLY=6, REPEAT_RATE=3.)
1. Set 23:59:59 via set modes, then mode=00, enable=1 -> after 4 cycles: 00:00:00, with sec_pulse=1 and day_pulse=1 for exactly one cycle; no change while enable=0.
2. mode=10, mins=0, single minus pulse -> mins=59, hours unchanged. mode=01, secs=59, plus -> secs=0, mins unchanged (no carry).
3. mode=11, hours=0, plus held 13 cycles -> steps at held-cycles 0, 6, 9, 12 -> hours=4. Release and re-press -> 5 on the first edge.
4. plus and minus both held 10 cycles in mode=10 -> mins unchanged. Reset asserted mid-hold in mode=11 -> all fields 0 next cycle, and no step until a fresh press.
5. fmt12=1: hours 0 -> disp 12/pm0; 11 -> 11/pm0; 12 -> 12/pm1; 13 -> 1/pm1; 23 -> 11/pm1. fmt12=0: hours 13 -> disp 13, pm0.
6. alarm_en=1, alarm=07:30. Time 07:29:59 run -> alarm_match one cycle with sec_pulse. Setting 07:30:00 via mode=10 -> no alarm_match. alarm_en=0 -> no match.
